// File: rtl/bdd_walk_engine.sv
// Evaluates one reduced ordered BDD per output channel over a latched input vector, walking one node per cycle.
// Latency: sum over channels of (nodes visited + 1) + 1 cycles. Holds the result until out_ready; only one vector in flight.
module bdd_walk_engine #(
    parameter  int IN_W      = 1894,
    parameter  int NUM_OUT   = 8,
    parameter  int NODES     = 128,
    parameter  int MAX_STEPS = 255,
    localparam int PTR_W     = $clog2(NODES),
    localparam int IDX_W     = $clog2(IN_W),
    localparam int PW        = PTR_W + 1,
    localparam int CFG_W     = IDX_W + 2 * PW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [PTR_W-1:0]   cfg_addr,
    input  logic [CFG_W-1:0]   cfg_wdata,
    output logic               cfg_ready,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] o,
    output logic               err,
    output logic               busy
);

    localparam int CH_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int ST_W = $clog2(MAX_STEPS + 1);
    localparam logic [PTR_W:0]    NODES_L = PW'(NODES);
    localparam logic [PTR_W:0]    NOUT_L  = PW'(NUM_OUT);
    localparam logic [IDX_W:0]    INW_L   = (IDX_W + 1)'(IN_W);
    localparam logic [ST_W-1:0]   MAXS_L  = ST_W'(MAX_STEPS);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    typedef struct packed {
        logic [IDX_W-1:0] var_idx;
        logic [PTR_W:0]   lo;
        logic [PTR_W:0]   hi;
    } node_t;

    node_t            nodes_q [NODES];
    logic [PTR_W:0]   roots_q [NUM_OUT];

    state_t           state_q;
    logic [IN_W-1:0]  i_q;
    logic [PTR_W:0]   cur_q;
    logic [CH_W-1:0]  ch_q;
    logic [ST_W-1:0]  steps_q;
    logic [NUM_OUT-1:0] o_acc_q;
    logic             err_acc_q;
    logic [NUM_OUT-1:0] o_q;
    logic             err_q;

    logic             node_wr, root_wr;
    logic [CH_W-1:0]  root_widx;
    logic [PTR_W:0]   root0_eff;
    logic [PTR_W-1:0] node_idx;
    logic             is_term, ptr_bad, step_lim, chan_done, in_rng, sel_bit, last_ch;
    node_t            node_rd;
    logic [CH_W-1:0]  ch_nxt;
    logic [PTR_W:0]   root_nxt;
    logic [NUM_OUT-1:0] acc_nxt;

    always_comb begin
        node_wr   = 1'b0;
        root_wr   = 1'b0;
        root_widx = cfg_addr[CH_W-1:0];
        if (cfg_we && state_q == IDLE) begin
            node_wr = !cfg_sel && ({1'b0, cfg_addr} < NODES_L);
            root_wr = cfg_sel && ({1'b0, cfg_addr} < NOUT_L);
        end
        // A root-0 write in the accepting cycle must be seen by the walk it starts.
        root0_eff = (root_wr && root_widx == '0) ? cfg_wdata[PTR_W:0] : roots_q[0];
    end

    always_ff @(posedge clk) begin
        if (node_wr) nodes_q[cfg_addr] <= node_t'(cfg_wdata);
        if (root_wr) roots_q[root_widx] <= cfg_wdata[PTR_W:0];
    end

    always_comb begin
        node_idx  = cur_q[PTR_W-1:0];
        is_term   = cur_q[PTR_W];
        ptr_bad   = !is_term && ({1'b0, node_idx} >= NODES_L);
        step_lim  = !is_term && (steps_q == MAXS_L);
        chan_done = is_term || ptr_bad || step_lim;
        node_rd   = ptr_bad ? '0 : nodes_q[node_idx];
        in_rng    = {1'b0, node_rd.var_idx} < INW_L;
        sel_bit   = in_rng ? i_q[node_rd.var_idx] : 1'b0;
        last_ch   = (ch_q == LAST_CH);
        ch_nxt    = ch_q + CH_W'(1);
        root_nxt  = last_ch ? '0 : roots_q[ch_nxt];
        acc_nxt   = o_acc_q;
        acc_nxt[ch_q] = is_term & cur_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            cur_q     <= '0;
            ch_q      <= '0;
            steps_q   <= '0;
            o_acc_q   <= '0;
            err_acc_q <= 1'b0;
            o_q       <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        i_q       <= i;
                        o_acc_q   <= '0;
                        err_acc_q <= 1'b0;
                        ch_q      <= '0;
                        cur_q     <= root0_eff;
                        steps_q   <= '0;
                        state_q   <= WALK;
                    end
                end
                WALK: begin
                    if (chan_done) begin
                        o_acc_q <= acc_nxt;
                        if (!is_term) err_acc_q <= 1'b1;
                        if (last_ch) begin
                            o_q     <= acc_nxt;
                            err_q   <= err_acc_q | !is_term;
                            state_q <= DONE;
                        end else begin
                            ch_q    <= ch_nxt;
                            cur_q   <= root_nxt;
                            steps_q <= '0;
                        end
                    end else begin
                        cur_q   <= sel_bit ? node_rd.hi : node_rd.lo;
                        steps_q <= steps_q + ST_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign o         = o_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bdd_walk_engine.sv
// Scoreboard bench for bdd_walk_engine: a loop-level BDD evaluator predicts o, err and latency per accepted vector.
module tb_bdd_walk_engine;

    localparam int IN_W = 1894;
    localparam int NUM_OUT = 8;
    localparam int NODES = 100;
    localparam int MAX_STEPS = 255;
    localparam int PTR_W = 7;
    localparam int CFG_W = 27;
    localparam logic [7:0] T0 = 8'h80;
    localparam logic [7:0] T1 = 8'h81;

    logic clk, rst;
    logic cfg_we, cfg_sel, cfg_ready;
    logic [PTR_W-1:0] cfg_addr;
    logic [CFG_W-1:0] cfg_wdata;
    logic in_valid, in_ready, out_valid, out_ready, err, busy, hold;
    logic [IN_W-1:0] i;
    logic [NUM_OUT-1:0] o;

    typedef struct {
        logic [7:0] o;
        logic       e;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   nchk, nerr, cyc;
    bit   seen;

    int         m_var [NODES];
    logic [7:0] m_lo [NODES];
    logic [7:0] m_hi [NODES];
    logic [7:0] m_root [NUM_OUT];

    bdd_walk_engine #(.IN_W(IN_W), .NUM_OUT(NUM_OUT), .NODES(NODES), .MAX_STEPS(MAX_STEPS)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready),
        .i(i), .out_valid(out_valid), .out_ready(out_ready), .o(o), .err(err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endfunction

    // Evaluate every channel's BDD directly from the table contents.
    function automatic void model_eval(input logic [IN_W-1:0] v, output logic [7:0] ob,
                                       output logic eb, output int lat);
        logic [7:0] p;
        int n, idx;
        bit b;
        ob = '0; eb = 1'b0; lat = 1;
        for (int ch = 0; ch < NUM_OUT; ch++) begin
            p = m_root[ch];
            n = 0;
            while (1) begin
                idx = int'(p[6:0]);
                if (p[7]) begin ob[ch] = p[0]; break; end
                if (idx >= NODES || n == MAX_STEPS) begin eb = 1'b1; break; end
                b = (m_var[idx] < IN_W) ? v[m_var[idx]] : 1'b0;
                p = b ? m_hi[idx] : m_lo[idx];
                n++;
            end
            lat += n + 1;
        end
    endfunction

    function automatic logic [IN_W-1:0] rand_vec();
        logic [IN_W-1:0] v;
        for (int k = 0; k < IN_W; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic wr_node(input int idx, input int vr, input logic [7:0] lo, input logic [7:0] hi, input bit upd);
        logic [10:0] vb;
        vb = 11'(vr);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 7'(idx); cfg_wdata = {vb, lo, hi};
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (upd && idx < NODES) begin m_var[idx] = vr; m_lo[idx] = lo; m_hi[idx] = hi; end
    endtask

    task automatic wr_root(input int idx, input logic [7:0] val, input bit upd);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 7'(idx); cfg_wdata = {19'd0, val};
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (upd && idx < NUM_OUT) m_root[idx] = val;
    endtask

    task automatic send(input logic [IN_W-1:0] v, input bit r0_wr, input logic [7:0] r0);
        exp_t e;
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        i = v; in_valid = 1'b1;
        if (r0_wr) begin cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = '0; cfg_wdata = {19'd0, r0}; end
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            nchk++; nerr++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end else begin
            if (r0_wr) m_root[0] = r0;
            model_eval(v, e.o, e.e, e.lat);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; cfg_we = 1'b0;
        i = ~v;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 4000 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            nchk++; nerr++;
            $display("FAIL done_timeout: got %0d pending required 0", sb.size());
            sb.delete(); seen = 0;
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    nchk++; nerr++;
                    $display("FAIL unexpected_out_valid: got o=%0h required no result", o);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1;
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    chk("o", 32'(o), 32'(e.o));
                    chk("err", 32'(err), 32'(e.e));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        logic [IN_W-1:0] v;
        int pool [8];
        int a;
        nchk = 0; nerr = 0; cyc = 0; seen = 0; hold = 1'b0;
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        in_valid = 1'b0; i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_o", 32'(o), 0);
        chk("rst_err", 32'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_cfg_ready", 32'(cfg_ready), 1);

        for (int n = 0; n < NODES; n++) wr_node(n, 0, T0, T0, 1);
        for (int r = 0; r < NUM_OUT; r++) wr_root(r, T0, 1);
        send(rand_vec(), 0, '0); wait_done();

        wr_node(10, 90, T0, T1, 1);
        wr_root(0, 8'd10, 1);
        v = rand_vec(); v[90] = 1'b1; send(v, 0, '0); wait_done();
        v[90] = 1'b0; send(v, 0, '0); wait_done();

        wr_node(0, 1722, 8'd1, 8'd2, 1);
        wr_node(1, 1725, T0, T1, 1);
        wr_node(2, 1725, T1, T0, 1);
        wr_root(3, 8'd0, 1);
        for (int c = 0; c < 4; c++) begin
            v = rand_vec(); v[1722] = c[0]; v[1725] = c[1];
            send(v, 0, '0); wait_done();
        end

        wr_node(5, 0, 8'd5, 8'd5, 1);
        wr_root(1, 8'd5, 1);
        send(rand_vec(), 0, '0); wait_done();

        wr_root(2, 8'd127, 1);
        wr_node(20, 2000, T1, T0, 1);
        wr_root(4, 8'd20, 1);
        send(rand_vec(), 0, '0); wait_done();

        for (int k = 0; k < 7; k++) pool[k] = $urandom_range(0, IN_W - 1);
        pool[7] = 1900 + $urandom_range(0, 140);
        for (int n = 30; n < 70; n++) begin
            logic [7:0] lo, hi;
            lo = (n == 69 || $urandom_range(0, 2) == 0) ? 8'(8'h80 | $urandom_range(0, 1)) : 8'($urandom_range(n + 1, 69));
            hi = (n == 69 || $urandom_range(0, 2) == 0) ? 8'(8'h80 | $urandom_range(0, 1)) : 8'($urandom_range(n + 1, 69));
            wr_node(n, pool[$urandom_range(0, 7)], lo, hi, 1);
        end
        for (int r = 5; r < 8; r++) wr_root(r, 8'($urandom_range(30, 45)), 1);
        for (int k = 0; k < 12; k++) begin send(rand_vec(), 0, '0); wait_done(); end

        wr_root(9, T1, 1);
        send(rand_vec(), 0, '0); wait_done();

        hold = 1'b1;
        v = rand_vec(); v[90] = 1'b1;
        send(v, 0, '0);
        for (int k = 0; k < 2000 && !out_valid; k++) @(negedge clk);
        chk("hold_reached_valid", 32'(out_valid), 1);
        repeat (10) @(negedge clk);
        hold = 1'b0;
        wait_done();

        v = rand_vec(); v[90] = 1'b1;
        send(v, 0, '0);
        @(negedge clk);
        chk("busy_cfg_ready", 32'(cfg_ready), 0);
        wr_node(10, 90, T1, T0, 0);
        wr_root(0, T1, 0);
        wait_done();
        v = rand_vec(); v[90] = 1'b1;
        send(v, 0, '0); wait_done();

        a = $urandom_range(0, 1);
        send(rand_vec(), 1, a[0] ? T1 : T0); wait_done();
        wr_root(0, 8'd10, 1);

        v = rand_vec(); v[90] = 1'b1;
        send(v, 0, '0);
        repeat (40) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("midwalk_rst_busy", 32'(busy), 0);
        chk("midwalk_rst_out_valid", 32'(out_valid), 0);
        chk("midwalk_rst_o", 32'(o), 0);
        chk("midwalk_rst_err", 32'(err), 0);
        sb.delete(); seen = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        send(v, 0, '0); wait_done();
        send(rand_vec(), 0, '0); wait_done();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
